// File: rtl/coeff_token_encoder.sv
// CAVLC coeff_token encoder (H.264 Table 9-5).
// Two-stage valid/ready pipeline: S1 registers and classifies the token,
// S2 holds the MSB-aligned codeword, its length and an error flag.
// A running bit counter totals the lengths of legal codewords emitted.
module coeff_token_encoder (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [4:0]  total_coeff_i,
    input  logic [1:0]  trailing_ones_i,
    input  logic [4:0]  nc_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [15:0] code_word_o,
    output logic [4:0]  code_len_o,
    output logic        error_o,
    output logic [15:0] bit_count_o,
    input  logic        count_clear_i
);

    localparam logic [2:0] CLS_A  = 3'd0;  // 0 <= nC < 2
    localparam logic [2:0] CLS_B  = 3'd1;  // 2 <= nC < 4
    localparam logic [2:0] CLS_C  = 3'd2;  // 4 <= nC < 8
    localparam logic [2:0] CLS_D  = 3'd3;  // 8 <= nC <= 16, fixed length
    localparam logic [2:0] CLS_N1 = 3'd4;  // chroma DC 4:2:0
    localparam logic [2:0] CLS_N2 = 3'd5;  // chroma DC 4:2:2

    // VLC tables indexed by {TotalCoeff, TrailingOnes}. Each entry is the
    // code length and the code value right-aligned; entries with
    // TrailingOnes > TotalCoeff are unreachable and left at zero.
    // NOTE: these are constant ROMs, so there is no storage to reset; only
    // the pipeline registers below carry reset.
    localparam logic [4:0] LEN_A [0:67] = '{
        1, 0, 0, 0,    6, 2, 0, 0,    8, 6, 3, 0,    9, 8, 7, 5,
        10, 9, 8, 6,   11, 10, 9, 7,  13, 11, 10, 8, 13, 13, 11, 9,
        13, 13, 13, 10, 14, 14, 13, 11, 14, 14, 14, 13, 15, 15, 14, 14,
        15, 15, 15, 14, 16, 15, 15, 15, 16, 16, 16, 15, 16, 16, 16, 16,
        16, 16, 16, 16};
    localparam logic [3:0] VAL_A [0:67] = '{
        1, 0, 0, 0,    5, 1, 0, 0,    7, 4, 1, 0,    7, 6, 5, 3,
        7, 6, 5, 3,    7, 6, 5, 4,    15, 6, 5, 4,   11, 14, 5, 4,
        8, 10, 13, 4,  15, 14, 9, 4,  11, 10, 13, 12, 15, 14, 9, 12,
        11, 10, 13, 8, 15, 1, 9, 12,  11, 14, 13, 8, 7, 10, 9, 12,
        4, 6, 5, 8};
    localparam logic [4:0] LEN_B [0:67] = '{
        2, 0, 0, 0,    6, 2, 0, 0,    6, 5, 3, 0,    7, 6, 6, 4,
        8, 6, 6, 4,    8, 7, 7, 5,    9, 8, 8, 6,    11, 9, 9, 6,
        11, 11, 11, 7, 12, 11, 11, 9, 12, 12, 12, 11, 12, 12, 12, 11,
        13, 13, 13, 12, 13, 13, 13, 13, 13, 14, 13, 13, 14, 14, 14, 13,
        14, 14, 14, 14};
    localparam logic [3:0] VAL_B [0:67] = '{
        3, 0, 0, 0,    11, 2, 0, 0,   7, 7, 3, 0,    7, 10, 9, 5,
        7, 6, 5, 4,    4, 6, 5, 6,    7, 6, 5, 8,    15, 6, 5, 4,
        11, 14, 13, 4, 15, 10, 9, 4,  11, 14, 13, 12, 8, 10, 9, 8,
        15, 14, 13, 12, 11, 10, 9, 12, 7, 11, 6, 8,  9, 8, 10, 1,
        7, 6, 5, 4};
    localparam logic [4:0] LEN_C [0:67] = '{
        4, 0, 0, 0,    6, 4, 0, 0,    6, 5, 4, 0,    6, 5, 5, 4,
        7, 5, 5, 4,    7, 5, 5, 4,    7, 6, 6, 4,    7, 6, 6, 4,
        8, 7, 7, 5,    8, 8, 7, 6,    9, 8, 8, 7,    9, 9, 8, 8,
        9, 9, 9, 8,    10, 9, 9, 9,   10, 10, 10, 10, 10, 10, 10, 10,
        10, 10, 10, 10};
    localparam logic [3:0] VAL_C [0:67] = '{
        15, 0, 0, 0,   15, 14, 0, 0,  11, 15, 13, 0, 8, 12, 14, 12,
        15, 10, 11, 11, 11, 8, 9, 10, 9, 14, 13, 9,  8, 10, 9, 8,
        15, 14, 13, 13, 11, 14, 10, 12, 15, 10, 13, 12, 11, 14, 9, 12,
        8, 10, 13, 8,  13, 7, 9, 12,  9, 12, 11, 10, 5, 8, 7, 6,
        1, 4, 3, 2};
    localparam logic [4:0] LEN_N1 [0:19] = '{
        2, 0, 0, 0,    6, 1, 0, 0,    6, 6, 3, 0,    6, 7, 7, 6,
        6, 8, 8, 7};
    localparam logic [3:0] VAL_N1 [0:19] = '{
        1, 0, 0, 0,    7, 1, 0, 0,    4, 6, 1, 0,    3, 3, 2, 5,
        2, 3, 2, 0};
    localparam logic [4:0] LEN_N2 [0:35] = '{
        1, 0, 0, 0,    7, 2, 0, 0,    7, 7, 3, 0,    9, 7, 7, 5,
        9, 9, 7, 6,    10, 10, 9, 7,  11, 11, 10, 7, 12, 12, 11, 10,
        13, 12, 12, 11};
    localparam logic [3:0] VAL_N2 [0:35] = '{
        1, 0, 0, 0,    15, 1, 0, 0,   14, 13, 1, 0,  7, 12, 11, 1,
        6, 5, 10, 1,   7, 6, 4, 9,    7, 6, 5, 8,    7, 6, 5, 4,
        7, 5, 4, 4};

    logic        s1_valid_q;
    logic [4:0]  s1_tc_q;
    logic [1:0]  s1_t1_q;
    logic [2:0]  s1_cls_q, s1_cls_d;
    logic        s1_legal_q, s1_legal_d;
    logic        out_valid_q;
    logic [15:0] code_word_q, code_word_d;
    logic [4:0]  code_len_q, code_len_d;
    logic        error_q, error_d;
    logic [15:0] bit_count_q, bit_count_d;
    logic        s2_adv;
    logic [6:0]  idx;
    logic [4:0]  ent_len;
    logic [3:0]  ent_val;
    logic [4:0]  tc_m1;

    assign s2_adv      = !out_valid_q || out_ready_i;
    assign in_ready_o  = !s1_valid_q || s2_adv;
    assign out_valid_o = out_valid_q;
    assign code_word_o = code_word_q;
    assign code_len_o  = code_len_q;
    assign error_o     = error_q;
    assign bit_count_o = bit_count_q;

    // Classify the incoming token by nC and check it against the table limits.
    // NOTE: every always_comb output gets a default first so no path leaves a
    // value unassigned and infers a latch.
    always_comb begin
        s1_cls_d   = CLS_D;
        s1_legal_d = 1'b1;
        if (nc_i == 5'd30)      s1_cls_d = CLS_N1;
        else if (nc_i == 5'd31) s1_cls_d = CLS_N2;
        else if (nc_i < 5'd2)   s1_cls_d = CLS_A;
        else if (nc_i < 5'd4)   s1_cls_d = CLS_B;
        else if (nc_i < 5'd8)   s1_cls_d = CLS_C;
        else if (nc_i > 5'd16)  s1_legal_d = 1'b0;
        if ({3'b000, trailing_ones_i} > total_coeff_i) s1_legal_d = 1'b0;
        if (total_coeff_i > 5'd16)                      s1_legal_d = 1'b0;
        if (s1_cls_d == CLS_N1 && total_coeff_i > 5'd4) s1_legal_d = 1'b0;
        if (s1_cls_d == CLS_N2 && total_coeff_i > 5'd8) s1_legal_d = 1'b0;
    end

    // Table lookup of the S1 token into an MSB-aligned codeword.
    always_comb begin
        idx         = s1_legal_q ? {s1_tc_q, s1_t1_q} : 7'd0;
        tc_m1       = s1_tc_q - 5'd1;
        ent_len     = 5'd0;
        ent_val     = 4'd0;
        code_word_d = 16'h0000;
        code_len_d  = 5'd0;
        error_d     = !s1_legal_q;
        case (s1_cls_q)
            CLS_A:   begin ent_len = LEN_A[idx];       ent_val = VAL_A[idx];       end
            CLS_B:   begin ent_len = LEN_B[idx];       ent_val = VAL_B[idx];       end
            CLS_C:   begin ent_len = LEN_C[idx];       ent_val = VAL_C[idx];       end
            CLS_N1:  begin ent_len = LEN_N1[idx[4:0]]; ent_val = VAL_N1[idx[4:0]]; end
            CLS_N2:  begin ent_len = LEN_N2[idx[5:0]]; ent_val = VAL_N2[idx[5:0]]; end
            default: ;
        endcase
        if (s1_legal_q) begin
            if (s1_cls_q == CLS_D) begin
                code_len_d  = 5'd6;
                code_word_d = (s1_tc_q == 5'd0) ? 16'h0C00 : {tc_m1[3:0], s1_t1_q, 10'b0};
            end else begin
                code_len_d  = ent_len;
                code_word_d = {12'b0, ent_val} << (5'd16 - ent_len);
            end
        end
    end

    // Emitted-bit counter; a clear wins over a concurrent beat.
    always_comb begin
        bit_count_d = bit_count_q;
        if (count_clear_i)
            bit_count_d = 16'h0000;
        else if (out_valid_q && out_ready_i && !error_q)
            bit_count_d = bit_count_q + {11'b0, code_len_q};
    end

    // Pipeline registers: S2 loads from S1 when free or drained, S1 loads on accept.
    // NOTE: non-blocking assignments so every register samples pre-edge values,
    // which is what lets S1 hand over to S2 and reload in the same cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_valid_q  <= 1'b0;
            s1_tc_q     <= 5'd0;
            s1_t1_q     <= 2'd0;
            s1_cls_q    <= CLS_A;
            s1_legal_q  <= 1'b0;
            out_valid_q <= 1'b0;
            code_word_q <= 16'h0000;
            code_len_q  <= 5'd0;
            error_q     <= 1'b0;
            bit_count_q <= 16'h0000;
        end else begin
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    code_word_q <= code_word_d;
                    code_len_q  <= code_len_d;
                    error_q     <= error_d;
                end
            end
            if (in_ready_o) begin
                s1_valid_q <= in_valid_i;
                if (in_valid_i) begin
                    s1_tc_q    <= total_coeff_i;
                    s1_t1_q    <= trailing_ones_i;
                    s1_cls_q   <= s1_cls_d;
                    s1_legal_q <= s1_legal_d;
                end
            end
            bit_count_q <= bit_count_d;
        end
    end

endmodule
